serv_fetch: RTL and testbench
=============================

SERV_FETCH -- requirements
Module: serv_fetch

Interface
REQ-001 SHALL have parameter WITH_C, default 1: enables 16-bit instruction support and halfword-aligned PCs.
REQ-002 SHALL have ports (name, direction, width, meaning), in this order:
- clk  in  1  the only clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_fetch_req  in  1  single-cycle pulse: PC is final, fetch the next instruction.
- i_pc  in  32  PC, from the PC/control stage's bus address.
- i_flush  in  1  invalidates the buffered word (fence.i, self-modifying code).
- o_ibus_adr  out  32  word address; bits [1:0] always 0.
- o_ibus_cyc  out  1  bus request.
- i_ibus_rdt  in  32  bus read data.
- i_ibus_ack  in  1  read data valid; ends the bus cycle.
- o_insn  out  32  instruction; 16-bit instructions in [15:0], [31:16]=0.
- o_insn_valid  out  1  one-cycle pulse: o_insn and o_iscomp valid.
- o_iscomp  out  1  instruction is 16-bit, i.e. low two bits != 2'b11; feeds the PC stage's increment select.
- o_busy  out  1  fetch in progress.

Function
REQ-003 FSM states SHALL be IDLE, LO (fetch word at pc[31:2]), HI (fetch word at pc[31:2]+1) and DONE (pulse valid).
REQ-004 IDLE + i_fetch_req SHALL latch i_pc and set o_busy, with o_busy held until the cycle o_insn_valid is high.
REQ-005 i_fetch_req while o_busy SHALL be ignored; the bench SHALL flag it as a protocol error.
REQ-006 If pc[1]=0 or WITH_C=0, the FSM SHALL go to LO; on ack, o_insn = rdt when rdt[1:0]=11, else {16'b0, rdt[15:0]}.
REQ-007 If pc[1]=1 and the buffer hits (valid, tag==pc[31:2]):
- upper half is 16-bit: go straight to DONE, no bus cycle.
- upper half is 32-bit: go to HI.
REQ-008 If pc[1]=1 and the buffer misses: go to LO; on ack, compressed upper half -> DONE, else -> HI.
REQ-009 On ack in HI, o_insn SHALL be {rdt[15:0], word[31:16]}, where word is the buffered or LO-fetched word.
REQ-010 Every acked word SHALL be written to the buffer, tag = its word address [31:2], valid=1.
REQ-011 o_ibus_cyc SHALL rise the cycle after entering LO/HI and stay high until the ack cycle, with o_ibus_adr stable throughout.
REQ-012 An ack SHALL be accepted in the cycle it arrives; o_ibus_cyc SHALL be 0 the next cycle; acks while cyc=0 SHALL be ignored.
REQ-013 o_insn_valid SHALL pulse exactly one cycle after the final ack, or one cycle after the request on a compressed buffer hit.
- o_insn/o_iscomp SHALL hold until the next valid pulse.
REQ-014 Wrap-around: HI address SHALL be computed modulo 2^32, so pc=0xFFFF_FFFE fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-015 i_flush SHALL clear buffer valid the next cycle.
- Flush in an ack cycle: the instruction SHALL still be delivered; the buffer SHALL end invalid.
- Flush with a request: the lookup SHALL see a miss.
REQ-016 Zero-wait-state slave (ack in the first cyc cycle): aligned fetch latency SHALL be 3 cycles request-to-valid; split fetch 5 cycles.

Reset
REQ-017 While i_rst_n=0, all outputs SHALL be 0 and the state IDLE.
REQ-018 The buffer valid bit SHALL be 0 and buffer data/tag SHALL be unreset.
REQ-019 Reset mid-transaction SHALL drop o_ibus_cyc asynchronously, abandon the fetch and emit no o_insn_valid.

Structure
REQ-020 FSM state encodings and the constant 2'b11 (32-bit length marker) SHALL live in the shared package serv_pkg.
REQ-021 The tagged one-word buffer SHALL be the sub-module serv_fetch_buf, with write, flush, lookup-hit and data outputs; the FSM and muxing SHALL stay in serv_fetch.

Verification
REQ-022 pc=0x100, ack after 2 wait states with rdt=0x00500093 -> adr=0x100, cyc high 3 cycles, o_insn=0x00500093, o_iscomp=0, single valid pulse.
REQ-023 pc=0x200, rdt=0x4505_0001 -> o_insn=0x0000_0001, o_iscomp=1; then pc=0x202 -> no cyc, o_insn=0x0000_4505, o_iscomp=1, valid 1 cycle after request.
REQ-024 pc=0x302 miss, word 0x302=0x0093_FFFF, word 0x304=0xAAAA_0050 -> two bus cycles (0x300, 0x304), o_insn=0x0050_0093, buffer tag 0x304.
REQ-025 pc=0xFFFF_FFFE, 32-bit split -> addresses 0xFFFF_FFFC then 0x0000_0000, correctly combined.
REQ-026 i_rst_n low while cyc=1 waiting for ack -> cyc 0 immediately, no valid pulse; a later ack is ignored; a new request after reset fetches normally.
REQ-027 Fill buffer at 0x400, pulse i_flush, request pc=0x402 -> bus fetch of 0x400 reissued, not served from the buffer.

Source files
------------

// File: rtl/serv_pkg.sv
// Shared definitions for the SERV instruction fetch slice.
//   fetch_state_e     : fetch FSM state encodings
//   INSN_LEN32        : low two bits that mark a 32-bit instruction
//   is_compressed()   : true when a halfword starts a 16-bit instruction
package serv_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,  // waiting for a fetch request
        FETCH_LO   = 2'd1,  // bus cycle for the word at pc[31:2]
        FETCH_HI   = 2'd2,  // bus cycle for the word at pc[31:2]+1
        FETCH_DONE = 2'd3   // instruction valid pulse
    } fetch_state_e;

    localparam logic [1:0] INSN_LEN32 = 2'b11;

    // Only the two length bits of a halfword decide its instruction size.
    function automatic logic is_compressed(input logic [1:0] low_bits);
        return low_bits != INSN_LEN32;
    endfunction

endpackage

// File: rtl/serv_fetch_buf.sv
// One-word tagged instruction buffer.
// Holds the most recently fetched bus word so that a halfword-aligned PC
// whose lower half lives in an already fetched word avoids a bus cycle.
// Ports:
//   clk, i_rst_n     : clock, asynchronous active-low reset (valid bit only)
//   i_wr_en          : write i_wr_data with tag i_wr_tag, set valid
//   i_wr_tag         : word address [31:2] of the written word
//   i_wr_data        : written bus word
//   i_flush          : clear valid next cycle; also masks the current lookup
//   i_lookup_tag     : word address [31:2] to compare against
//   o_hit            : valid, tag matches, and no flush this cycle
//   o_data           : buffered word
module serv_fetch_buf (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_wr_en,
    input  logic [29:0] i_wr_tag,
    input  logic [31:0] i_wr_data,
    input  logic        i_flush,
    input  logic [29:0] i_lookup_tag,
    output logic        o_hit,
    output logic [31:0] o_data
);

    logic        valid_q, valid_d;
    logic [29:0] tag_q, tag_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (i_wr_en) begin
            valid_d = 1'b1;
            tag_d   = i_wr_tag;
            data_d  = i_wr_data;
        end
        // A flush coinciding with a write still leaves the buffer invalid.
        if (i_flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign o_hit  = valid_q && !i_flush && (tag_q == i_lookup_tag);
    assign o_data = data_q;

endmodule

// File: rtl/serv_fetch.sv
// Instruction fetch unit: turns a single-cycle fetch request into one or two
// word reads on a simple cyc/ack bus and assembles the instruction, handling
// 16-bit instructions and 32-bit instructions that straddle a word boundary.
// Handshake: o_ibus_cyc is a registered request held with a stable
// o_ibus_adr until the cycle i_ibus_ack is seen; the ack is consumed in that
// cycle and o_ibus_cyc is low in the next one. Acks while o_ibus_cyc is low
// are ignored.
// Ports:
//   clk, i_rst_n   : clock, asynchronous active-low reset
//   i_fetch_req    : pulse, i_pc is final, fetch the instruction there
//   i_pc           : instruction address (halfword aligned when WITH_C)
//   i_flush        : invalidate the buffered word
//   o_ibus_adr     : word address, bits [1:0] zero
//   o_ibus_cyc     : bus request
//   i_ibus_rdt     : bus read data
//   i_ibus_ack     : read data valid, ends the bus cycle
//   o_insn         : instruction, 16-bit ones zero-extended
//   o_insn_valid   : one-cycle pulse, o_insn/o_iscomp valid
//   o_iscomp       : instruction is 16-bit
//   o_busy         : fetch in progress
module serv_fetch
    import serv_pkg::*;
#(
    parameter int unsigned WITH_C = 1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_req,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic [31:0] o_ibus_adr,
    output logic        o_ibus_cyc,
    input  logic [31:0] i_ibus_rdt,
    input  logic        i_ibus_ack,
    output logic [31:0] o_insn,
    output logic        o_insn_valid,
    output logic        o_iscomp,
    output logic        o_busy
);

    localparam bit C_EN = (WITH_C != 0);

    fetch_state_e state_q, state_d;
    logic [31:1]  pc_q, pc_d;
    logic         cyc_q, cyc_d;
    logic [15:0]  upper_q, upper_d;   // upper half of the first word of a split insn
    logic [31:0]  insn_q, insn_d;
    logic         iscomp_q, iscomp_d;

    logic         buf_wr;
    logic         buf_hit;
    logic [31:0]  buf_data;
    logic [29:0]  lo_word;
    logic [29:0]  hi_word;
    logic         ack_taken;

    logic         unused_pc0;
    logic [15:0]  unused_buf_lo;

    assign unused_pc0    = i_pc[0];
    assign unused_buf_lo = buf_data[15:0];

    assign lo_word   = pc_q[31:2];
    assign hi_word   = pc_q[31:2] + 30'd1;   // wraps modulo 2^32
    assign ack_taken = cyc_q && i_ibus_ack;

    serv_fetch_buf u_buf (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_wr_en      (buf_wr),
        .i_wr_tag     ((state_q == FETCH_HI) ? hi_word : lo_word),
        .i_wr_data    (i_ibus_rdt),
        .i_flush      (i_flush),
        .i_lookup_tag (i_pc[31:2]),
        .o_hit        (buf_hit),
        .o_data       (buf_data)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cyc_d    = 1'b0;
        upper_d  = upper_q;
        insn_d   = insn_q;
        iscomp_d = iscomp_q;
        buf_wr   = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                if (i_fetch_req) begin
                    pc_d    = i_pc[31:1];
                    state_d = FETCH_LO;
                    if (C_EN && i_pc[1] && buf_hit) begin
                        if (is_compressed(buf_data[17:16])) begin
                            state_d  = FETCH_DONE;
                            insn_d   = {16'h0000, buf_data[31:16]};
                            iscomp_d = 1'b1;
                        end else begin
                            state_d = FETCH_HI;
                            upper_d = buf_data[31:16];
                        end
                    end
                end
            end

            FETCH_LO: begin
                if (ack_taken) begin
                    buf_wr = 1'b1;
                    if (C_EN && pc_q[1]) begin
                        if (is_compressed(i_ibus_rdt[17:16])) begin
                            state_d  = FETCH_DONE;
                            insn_d   = {16'h0000, i_ibus_rdt[31:16]};
                            iscomp_d = 1'b1;
                        end else begin
                            state_d = FETCH_HI;
                            upper_d = i_ibus_rdt[31:16];
                        end
                    end else begin
                        state_d  = FETCH_DONE;
                        iscomp_d = is_compressed(i_ibus_rdt[1:0]);
                        insn_d   = is_compressed(i_ibus_rdt[1:0]) ?
                                   {16'h0000, i_ibus_rdt[15:0]} : i_ibus_rdt;
                    end
                end else begin
                    cyc_d = 1'b1;
                end
            end

            FETCH_HI: begin
                if (ack_taken) begin
                    buf_wr   = 1'b1;
                    state_d  = FETCH_DONE;
                    insn_d   = {i_ibus_rdt[15:0], upper_q};
                    iscomp_d = 1'b0;
                end else begin
                    cyc_d = 1'b1;
                end
            end

            FETCH_DONE: begin
                state_d = FETCH_IDLE;
            end

            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= FETCH_IDLE;
            pc_q     <= '0;
            cyc_q    <= 1'b0;
            upper_q  <= '0;
            insn_q   <= '0;
            iscomp_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cyc_q    <= cyc_d;
            upper_q  <= upper_d;
            insn_q   <= insn_d;
            iscomp_q <= iscomp_d;
        end
    end

    assign o_ibus_adr   = {(state_q == FETCH_HI) ? hi_word : lo_word, 2'b00};
    assign o_ibus_cyc   = cyc_q;
    assign o_insn       = insn_q;
    assign o_iscomp     = iscomp_q;
    assign o_insn_valid = (state_q == FETCH_DONE);
    assign o_busy       = (state_q != FETCH_IDLE);

endmodule

// File: tb/tb_serv_fetch.sv
module tb_serv_fetch;

    logic        clk;
    logic        i_rst_n;
    logic        i_fetch_req;
    logic [31:0] i_pc;
    logic        i_flush;
    logic [31:0] o_ibus_adr;
    logic        o_ibus_cyc;
    logic [31:0] i_ibus_rdt;
    logic        i_ibus_ack;
    logic [31:0] o_insn;
    logic        o_insn_valid;
    logic        o_iscomp;
    logic        o_busy;

    serv_fetch #(.WITH_C(1)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_fetch_req  (i_fetch_req),
        .i_pc         (i_pc),
        .i_flush      (i_flush),
        .o_ibus_adr   (o_ibus_adr),
        .o_ibus_cyc   (o_ibus_cyc),
        .i_ibus_rdt   (i_ibus_rdt),
        .i_ibus_ack   (i_ibus_ack),
        .o_insn       (o_insn),
        .o_insn_valid (o_insn_valid),
        .o_iscomp     (o_iscomp),
        .o_busy       (o_busy)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    logic [31:0] mem [logic [31:0]];
    logic [32:0] exp_q[$];          // {iscomp, insn}
    logic [31:0] bus_log[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt = 0;
    int cyc_cycles = 0;
    int valid_cnt = 0;
    int valid_cyc = 0;
    int req_cyc = 0;
    int last_lat = 0;
    int adr_err = 0;
    int wait_states = 0;
    int v0 = 0;
    logic slave_hold = 1'b0;
    logic force_ack = 1'b0;
    logic prev_cyc = 1'b0;
    logic [31:0] prev_adr = '0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Reference model: instruction at pc from the memory image.
    function automatic logic [32:0] exp_of(input logic [31:0] pc);
        logic [31:0] lo;
        logic [31:0] hi;
        logic [15:0] h;
        lo = mem_rd({pc[31:2], 2'b00});
        if (!pc[1]) begin
            if (lo[1:0] != 2'b11) return {1'b1, 16'h0, lo[15:0]};
            return {1'b0, lo};
        end
        h = lo[31:16];
        if (h[1:0] != 2'b11) return {1'b1, 16'h0, h};
        hi = mem_rd({pc[31:2] + 30'd1, 2'b00});
        return {1'b0, hi[15:0], h};
    endfunction

    // ---------------- bus slave ----------------
    initial begin
        int wcnt;
        wcnt = 0;
        i_ibus_ack = 1'b0;
        i_ibus_rdt = '0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                i_ibus_ack = 1'b1;
                i_ibus_rdt = 32'hDEAD_BEEF;
            end else if (o_ibus_cyc && !i_ibus_ack && !slave_hold) begin
                if (wcnt == wait_states) begin
                    i_ibus_ack = 1'b1;
                    i_ibus_rdt = mem_rd(o_ibus_adr);
                    bus_log.push_back(o_ibus_adr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                i_ibus_ack = 1'b0;
                if (!o_ibus_cyc) wcnt = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [32:0] e;
        forever begin
            @(posedge clk);
            cyc_cnt++;
            #1;
            if (o_ibus_cyc) cyc_cycles++;
            if (o_ibus_cyc && ((o_ibus_adr[1:0] != 2'b00) ||
                               (prev_cyc && o_ibus_adr != prev_adr))) adr_err++;
            prev_cyc = o_ibus_cyc;
            prev_adr = o_ibus_adr;
            if (o_insn_valid) begin
                valid_cnt++;
                valid_cyc = cyc_cnt;
                if (exp_q.size() == 0) begin
                    check("spurious_valid", {32'h0, o_insn_valid}, 33'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("insn", {o_iscomp, o_insn}, e);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // flush_mode: 0 none, 1 with the request, 2 held through the whole fetch
    task automatic run_fetch(input logic [31:0] pc, input logic [32:0] exp_v,
                             input int ws, input int flush_mode);
        int n;
        n = 0;
        while (o_busy && n < 100) begin @(negedge clk); n++; end
        if (o_busy) check("request_while_busy", {32'h0, o_busy}, 33'd0);
        wait_states = ws;
        bus_log.delete();
        cyc_cycles = 0;
        exp_q.push_back(exp_v);
        v0 = valid_cnt;
        req_cyc = cyc_cnt;
        i_fetch_req = 1'b1;
        i_pc = pc;
        i_flush = (flush_mode != 0);
        @(negedge clk);
        i_fetch_req = 1'b0;
        i_flush = (flush_mode == 2);
        n = 0;
        while (valid_cnt == v0 && n < 200) begin @(negedge clk); n++; end
        i_flush = 1'b0;
        if (valid_cnt == v0) check("valid_timeout", {32'h0, 1'b0}, 33'd1);
        last_lat = valid_cyc - req_cyc;
    endtask

    task automatic check_bus(input string name, input int exp_bus,
                             input logic [31:0] adr0, input int exp_lat);
        check({name, "_bus_cnt"}, bus_log.size(), exp_bus);
        if (exp_bus > 0 && bus_log.size() > 0) check({name, "_adr0"}, {1'b0, bus_log[0]}, {1'b0, adr0});
        check({name, "_latency"}, last_lat, exp_lat);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] pc;
        int          ws;
        logic [31:0] w0;       // word at pc[31:2]
        logic [31:0] w1;       // word at pc[31:2]+1
        logic [32:0] expv;     // {iscomp, insn}
        int          exp_bus;
        logic [31:0] adr0;
        logic [31:0] adr1;
        int          exp_cyc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        logic [31:0] a;
        logic [31:0] pc;

        vecs[0] = '{32'h0000_0100, 2, 32'h0050_0093, 32'h0,         33'h0_0050_0093, 1, 32'h100,       32'h0, 3, 5};
        vecs[1] = '{32'h0000_0200, 0, 32'h4505_0001, 32'h0,         33'h1_0000_0001, 1, 32'h200,       32'h0, 1, 3};
        vecs[2] = '{32'h0000_0302, 0, 32'h0093_FFFF, 32'hAAAA_0050, 33'h0_0050_0093, 2, 32'h300,       32'h304, 2, 5};
        vecs[3] = '{32'hFFFF_FFFE, 1, 32'h0513_0000, 32'hBEEF_00A5, 33'h0_00A5_0513, 2, 32'hFFFF_FFFC, 32'h0, 4, 7};
        vecs[4] = '{32'h0000_0500, 3, 32'h0000_4501, 32'h0,         33'h1_0000_4501, 1, 32'h500,       32'h0, 4, 6};
        vecs[5] = '{32'h0000_0602, 0, 32'h8082_1111, 32'h0,         33'h1_0000_8082, 1, 32'h600,       32'h0, 1, 3};
        vecs[6] = '{32'h0000_0700, 1, 32'hFFFF_FFFF, 32'h0,         33'h0_FFFF_FFFF, 1, 32'h700,       32'h0, 2, 4};

        // reset
        i_rst_n = 1'b0;
        i_fetch_req = 1'b0;
        i_pc = '0;
        i_flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_adr_cyc", {o_ibus_adr, o_ibus_cyc}, 33'd0);
        check("rst_insn_valid", {o_insn, o_insn_valid}, 33'd0);
        check("rst_iscomp_busy", {31'h0, o_iscomp, o_busy}, 33'd0);
        i_rst_n = 1'b1;
        @(negedge clk);

        // table: each vector forces a buffer miss with a flush on the request
        for (int i = 0; i < 7; i++) begin
            mem[{vecs[i].pc[31:2], 2'b00}] = vecs[i].w0;
            mem[{vecs[i].pc[31:2], 2'b00} + 32'd4] = vecs[i].w1;
            run_fetch(vecs[i].pc, vecs[i].expv, vecs[i].ws, 1);
            check_bus($sformatf("vec%0d", i), vecs[i].exp_bus, vecs[i].adr0, vecs[i].exp_lat);
            check($sformatf("vec%0d_cyc_cycles", i), cyc_cycles, vecs[i].exp_cyc);
            if (vecs[i].exp_bus > 1 && bus_log.size() > 1)
                check($sformatf("vec%0d_adr1", i), {1'b0, bus_log[1]}, {1'b0, vecs[i].adr1});
        end
        repeat (3) @(negedge clk);
        check("insn_hold", {o_iscomp, o_insn}, vecs[6].expv);

        // compressed buffer hit: no bus cycle, valid one cycle after request
        mem[32'h200] = 32'h4505_0001;
        run_fetch(32'h200, 33'h1_0000_0001, 0, 1);
        run_fetch(32'h202, 33'h1_0000_4505, 0, 0);
        check_bus("hit_comp", 0, 32'h0, 1);

        // buffer holds the second word of a split fetch
        run_fetch(32'h302, 33'h0_0050_0093, 0, 1);
        run_fetch(32'h306, 33'h1_0000_AAAA, 0, 0);
        check_bus("hit_tag304", 0, 32'h0, 1);

        // hit whose upper half is 32-bit: only the HI word is read
        mem[32'h800] = 32'h0013_0001;
        mem[32'h804] = 32'h0000_0050;
        run_fetch(32'h800, 33'h1_0000_0001, 0, 0);
        run_fetch(32'h802, 33'h0_0050_0013, 0, 0);
        check_bus("hit_split", 1, 32'h804, 3);

        // standalone flush, then a request that would otherwise hit
        mem[32'h400] = 32'h0013_0001;
        mem[32'h404] = 32'h0000_0050;
        run_fetch(32'h400, 33'h1_0000_0001, 0, 0);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        run_fetch(32'h402, 33'h0_0050_0013, 0, 0);
        check_bus("flush_then_req", 2, 32'h400, 5);

        // flush in the request cycle
        run_fetch(32'h400, 33'h1_0000_0001, 0, 0);
        run_fetch(32'h402, 33'h0_0050_0013, 0, 1);
        check_bus("flush_with_req", 2, 32'h400, 5);

        // flush held across the ack cycle: insn delivered, buffer left invalid
        mem[32'hA00] = 32'h8082_0001;
        run_fetch(32'hA00, 33'h1_0000_0001, 1, 2);
        run_fetch(32'hA02, 33'h1_0000_8082, 0, 0);
        check_bus("flush_in_ack", 1, 32'hA00, 3);

        // reset while waiting for an ack
        slave_hold = 1'b1;
        @(negedge clk);
        i_fetch_req = 1'b1;
        i_pc = 32'h900;
        @(negedge clk);
        i_fetch_req = 1'b0;
        n = 0;
        while (!o_ibus_cyc && n < 20) begin @(negedge clk); n++; end
        check("rst_mid_cyc_before", {32'h0, o_ibus_cyc}, 33'd1);
        v0 = valid_cnt;
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_cyc_async", {31'h0, o_ibus_cyc, o_busy}, 33'd0);
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_no_valid", valid_cnt - v0, 33'd0);
        check("rst_mid_idle", {31'h0, o_ibus_cyc, o_busy}, 33'd0);
        slave_hold = 1'b0;
        mem[32'h900] = 32'h00A0_0513;
        run_fetch(32'h900, 33'h0_00A0_0513, 0, 0);
        check_bus("after_rst", 1, 32'h900, 3);

        // random fetches over a small region against the memory model
        for (int k = 0; k < 18; k++) begin
            a = 32'h1000 + 32'(k * 4);
            mem[a] = $urandom;
        end
        for (int k = 0; k < 24; k++) begin
            pc = 32'h1000 + 32'($urandom_range(0, 31) * 2);
            run_fetch(pc, exp_of(pc), $urandom_range(0, 2),
                      ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        repeat (4) @(negedge clk);
        check("adr_stable_aligned", adr_err, 33'd0);
        check("scoreboard_empty", exp_q.size(), 33'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
